// File: rtl/pid_pkg.sv
// Shared widths, FSM state encoding and the saturation helper for the PID stage.
package pid_pkg;

    localparam int ERR_W  = 16;
    localparam int GAIN_W = 16;
    localparam int OPD_W  = 17;
    localparam int PROD_W = 34;
    localparam int SAT_W  = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_P = 3'd1,
        MUL_I = 3'd2,
        MUL_D = 3'd3,
        SUM   = 3'd4
    } state_t;

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] x,
        input logic signed [SAT_W-1:0] lo,
        input logic signed [SAT_W-1:0] hi
    );
        logic signed [SAT_W-1:0] r;
        if (x < lo) begin
            r = lo;
        end else if (x > hi) begin
            r = hi;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/pid_if.sv
// Sample/gain/control inputs and duty/status outputs of the PID stage.
interface pid_if
    import pid_pkg::*;
#(
    parameter int PWM_W = 10
);
    logic signed [ERR_W-1:0]  error;
    logic                     error_valid;
    logic        [GAIN_W-1:0] kp;
    logic        [GAIN_W-1:0] ki;
    logic        [GAIN_W-1:0] kd;
    logic                     clr;
    logic        [PWM_W-1:0]  duty;
    logic                     duty_valid;
    logic                     busy;
    logic                     overrun;

    modport master (
        output error, error_valid, kp, ki, kd, clr,
        input  duty, duty_valid, busy, overrun
    );

    modport slave (
        input  error, error_valid, kp, ki, kd, clr,
        output duty, duty_valid, busy, overrun
    );
endinterface

// File: rtl/pid_sat.sv
// Combinational signed clamp of a W-bit value into [LO, HI], narrowed to OUT_W bits.
module pid_sat
    import pid_pkg::*;
#(
    parameter int                      W     = 40,
    parameter int                      OUT_W = 40,
    parameter logic signed [W-1:0]     LO    = '0,
    parameter logic signed [W-1:0]     HI    = '0
) (
    input  logic signed [W-1:0]     x,
    output logic        [OUT_W-1:0] y
);

    // Widen to the helper's width, clamp, then keep the low OUT_W bits.
    always_comb begin
        y = OUT_W'(sat_signed(SAT_W'(x), SAT_W'(LO), SAT_W'(HI)));
    end

endmodule

// File: rtl/pid_controller.sv
// Multi-cycle PID stage: one shared 17x17 multiplier sequenced by a five-state FSM,
// producing a saturated unsigned PWM duty word.
module pid_controller
    import pid_pkg::*;
#(
    parameter int PWM_W   = 10,
    parameter int FRAC    = 8,
    parameter int INT_LIM = 262143,
    parameter int ACC_W   = 40
) (
    input  logic clk,
    input  logic reset_b,
    pid_if.slave bus
);

    localparam logic signed [ACC_W-1:0] INT_HI  = ACC_W'(INT_LIM);
    localparam logic signed [ACC_W-1:0] INT_LO  = -INT_HI;
    localparam logic signed [ACC_W-1:0] DUTY_LO = '0;
    localparam logic signed [ACC_W-1:0] DUTY_HI = (ACC_W'(1) <<< PWM_W) - ACC_W'(1);

    state_t state_r, fsm_next_s, next_s;
    logic                     busy_r;
    logic                     duty_valid_r;
    logic                     overrun_r;
    logic        [PWM_W-1:0]  duty_r;
    logic signed [ERR_W-1:0]  e_r;
    logic signed [ERR_W-1:0]  e_prev_r;
    logic signed [OPD_W-1:0]  d_r;
    logic        [GAIN_W-1:0] kp_r, ki_r, kd_r;
    logic signed [PROD_W-1:0] p_r, dd_r;
    logic signed [ACC_W-1:0]  integ_r;

    logic signed [OPD_W-1:0]  opa_s, opb_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  integ_sum_s, integ_sat_s;
    logic signed [ACC_W-1:0]  sum_s, u_s;
    logic        [PWM_W-1:0]  duty_sat_s;

    // Next-state logic; clr overrides every transition back to IDLE.
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.error_valid) begin
                    fsm_next_s = MUL_P;
                end else begin
                    fsm_next_s = IDLE;
                end
            end
            MUL_P:   fsm_next_s = MUL_I;
            MUL_I:   fsm_next_s = MUL_D;
            MUL_D:   fsm_next_s = SUM;
            SUM:     fsm_next_s = IDLE;
            default: fsm_next_s = IDLE;
        endcase
        next_s = bus.clr ? IDLE : fsm_next_s;
    end

    // State register with busy registered alongside it.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != IDLE);
        end
    end

    // Shared multiplier operand select: gain is zero-extended, error/delta sign-extended.
    always_comb begin
        opa_s = '0;
        opb_s = '0;
        case (state_r)
            MUL_P: begin
                opa_s = {1'b0, kp_r};
                opb_s = {e_r[ERR_W-1], e_r};
            end
            MUL_I: begin
                opa_s = {1'b0, ki_r};
                opb_s = {e_r[ERR_W-1], e_r};
            end
            MUL_D: begin
                opa_s = {1'b0, kd_r};
                opb_s = d_r;
            end
            default: begin
                opa_s = '0;
                opb_s = '0;
            end
        endcase
    end

    assign prod_s      = PROD_W'(opa_s) * PROD_W'(opb_s);
    assign integ_sum_s = integ_r + ACC_W'(prod_s);
    assign sum_s       = ACC_W'(p_r) + integ_r + ACC_W'(dd_r);
    assign u_s         = sum_s >>> FRAC;

    pid_sat #(.W(ACC_W), .OUT_W(ACC_W), .LO(INT_LO), .HI(INT_HI)) u_int_sat (
        .x (integ_sum_s),
        .y (integ_sat_s)
    );

    pid_sat #(.W(ACC_W), .OUT_W(PWM_W), .LO(DUTY_LO), .HI(DUTY_HI)) u_duty_sat (
        .x (u_s),
        .y (duty_sat_s)
    );

    // Datapath: latch on acceptance, one multiply per state, publish duty in SUM.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            duty_r       <= '0;
            duty_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            e_r          <= '0;
            e_prev_r     <= '0;
            d_r          <= '0;
            kp_r         <= '0;
            ki_r         <= '0;
            kd_r         <= '0;
            p_r          <= '0;
            dd_r         <= '0;
            integ_r      <= '0;
        end else if (bus.clr) begin
            duty_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            e_prev_r     <= '0;
            integ_r      <= '0;
        end else begin
            duty_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.error_valid) begin
                        e_r      <= bus.error;
                        e_prev_r <= bus.error;
                        d_r      <= {bus.error[ERR_W-1], bus.error} - {e_prev_r[ERR_W-1], e_prev_r};
                        kp_r     <= bus.kp;
                        ki_r     <= bus.ki;
                        kd_r     <= bus.kd;
                    end
                end
                MUL_P: p_r     <= prod_s;
                MUL_I: integ_r <= integ_sat_s;
                MUL_D: dd_r    <= prod_s;
                SUM: begin
                    duty_r       <= duty_sat_s;
                    duty_valid_r <= 1'b1;
                end
                default: duty_valid_r <= 1'b0;
            endcase
            if ((state_r != IDLE) && bus.error_valid) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign bus.duty       = duty_r;
    assign bus.duty_valid = duty_valid_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_pid_controller.sv
// Directed bench for pid_controller: vector table plus latency, overrun, clr and reset-abort sequences.
module tb_pid_controller;
    import pid_pkg::*;

    logic clk = 1'b0;
    logic reset_b;
    always #5 clk = ~clk;

    pid_if #(.PWM_W(10)) bus ();

    pid_controller #(
        .PWM_W(10), .FRAC(8), .INT_LIM(262143), .ACC_W(40)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    typedef struct {
        bit do_clr;
        int kp;
        int ki;
        int kd;
        int err;
        int exp_duty;
    } vec_t;

    vec_t vecs [10];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic set_gains(input int kp, input int ki, input int kd);
        bus.kp = 16'(kp);
        bus.ki = 16'(ki);
        bus.kd = 16'(kd);
    endtask

    task automatic send(input int e);
        bus.error       = 16'(e);
        bus.error_valid = 1'b1;
        tick();
        bus.error_valid = 1'b0;
    endtask

    task automatic run_sample(input string name, input int e, input int exp);
        int early;
        early = 0;
        send(e);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (bus.duty_valid) early++;
        end
        check({name, "_early_valid"}, early, 0);
        tick();
        check({name, "_valid_n4"}, int'(bus.duty_valid), 1);
        check({name, "_duty"}, int'(bus.duty), exp);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{1'b0, 256, 0,   0,   -50,   0};
        vecs[1] = '{1'b0, 256, 0,   0,   2000,  1023};
        vecs[2] = '{1'b1, 0,   256, 0,   10,    10};
        vecs[3] = '{1'b0, 0,   256, 0,   10,    20};
        vecs[4] = '{1'b0, 0,   256, 0,   10,    30};
        vecs[5] = '{1'b0, 0,   256, 0,   30000, 1023};
        vecs[6] = '{1'b0, 0,   256, 0,   -1,    1022};
        vecs[7] = '{1'b1, 0,   0,   256, 100,   100};
        vecs[8] = '{1'b0, 0,   0,   256, 150,   50};
        vecs[9] = '{1'b1, 0,   0,   256, 150,   150};

        reset_b         = 1'b1;
        bus.error       = '0;
        bus.error_valid = 1'b0;
        bus.clr         = 1'b0;
        set_gains(0, 0, 0);
        repeat (3) tick();
        check("reset_duty", int'(bus.duty), 0);
        check("reset_duty_valid", int'(bus.duty_valid), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_overrun", int'(bus.overrun), 0);
        reset_b = 1'b0;
        tick();

        // Basic latency and busy window.
        set_gains(256, 0, 0);
        send(100);
        check("t1_busy_n1", int'(bus.busy), 1);
        cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (!bus.busy || bus.duty_valid) cnt++;
        end
        check("t1_busy_window", cnt, 0);
        tick();
        check("t1_valid_n4", int'(bus.duty_valid), 1);
        check("t1_duty", int'(bus.duty), 100);
        check("t1_busy_after", int'(bus.busy), 0);
        tick();
        check("t1_valid_pulse", int'(bus.duty_valid), 0);
        check("t1_duty_hold", int'(bus.duty), 100);

        // Gains changed after acceptance must not affect the result.
        send(300);
        set_gains(0, 0, 0);
        repeat (4) tick();
        check("latch_duty", int'(bus.duty), 300);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_clr) pulse_clr();
            set_gains(vecs[i].kp, vecs[i].ki, vecs[i].kd);
            run_sample($sformatf("vec%0d", i), vecs[i].err, vecs[i].exp_duty);
            tick();
        end

        // Overrun: second strobe two cycles into a computation is dropped.
        pulse_clr();
        set_gains(256, 0, 0);
        send(100);
        tick();
        bus.error       = 16'sd500;
        bus.error_valid = 1'b1;
        tick();
        bus.error_valid = 1'b0;
        tick();
        check("ovr_valid_n3", int'(bus.duty_valid), 0);
        tick();
        check("ovr_valid_n4", int'(bus.duty_valid), 1);
        check("ovr_duty", int'(bus.duty), 100);
        check("ovr_flag", int'(bus.overrun), 1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.duty_valid) cnt++;
        end
        check("ovr_dropped", cnt, 0);
        check("ovr_sticky", int'(bus.overrun), 1);
        pulse_clr();
        check("ovr_clr", int'(bus.overrun), 0);

        // clr and error_valid together: sample dropped, no overrun.
        bus.clr         = 1'b1;
        bus.error       = 16'sd77;
        bus.error_valid = 1'b1;
        tick();
        bus.clr         = 1'b0;
        bus.error_valid = 1'b0;
        check("clrv_busy", int'(bus.busy), 0);
        check("clrv_overrun", int'(bus.overrun), 0);
        repeat (5) tick();
        check("clrv_duty_hold", int'(bus.duty), 100);

        // Reset in the middle of a computation.
        pulse_clr();
        set_gains(0, 256, 256);
        run_sample("pre_rst", 40, 80);
        tick();
        send(60);
        tick();
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        check("rst_mid_duty", int'(bus.duty), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_valid", int'(bus.duty_valid), 0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.duty_valid) cnt++;
        end
        check("rst_mid_no_valid", cnt, 0);
        run_sample("post_rst", 20, 40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
